// File: rtl/breakout_pkg.sv
// Shared geometry, state encoding, colour codes and level tables for the breakout engine.
package breakout_pkg;
    localparam logic [9:0]  PF_LEFT     = 10'd160;
    localparam logic [9:0]  PF_RIGHT    = 10'd479;
    localparam logic [9:0]  PF_TOP      = 10'd120;
    localparam logic [9:0]  BRICK_TOP   = 10'd140;
    localparam logic [9:0]  BRICK_BOT   = 10'd180;
    localparam logic [10:0] BRICK_W     = 11'd60;
    localparam logic [9:0]  BAR_TOP     = 10'd353;
    localparam logic [9:0]  BAR_BOT     = 10'd357;
    localparam logic [9:0]  BAR_STEP    = 10'd10;
    localparam logic [9:0]  BALL_SZ     = 10'd8;
    localparam logic [9:0]  BAR_X_RST   = 10'd295;
    localparam logic [9:0]  BALL_X_RST  = 10'd316;
    localparam logic [9:0]  BALL_Y_PARK = 10'd345;
    localparam logic [9:0]  TICK_ROW    = 10'd481;

    localparam logic [2:0] RGB_BRICK = 3'b011;
    localparam logic [2:0] RGB_BAR   = 3'b110;
    localparam logic [2:0] RGB_BALL  = 3'b100;
    localparam logic [2:0] RGB_NONE  = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_RUN   = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_e;

    // Velocity kept as sign + magnitude; magnitude 0 means parked.
    typedef struct packed {
        logic       neg;
        logic [1:0] mag;
    } vel_t;

    function automatic logic [1:0] lvl_speed(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [9:0] lvl_bar_w(input logic [1:0] lvl);
        case (lvl)
            2'd0:    return 10'd50;
            2'd1:    return 10'd40;
            default: return 10'd30;
        endcase
    endfunction

    function automatic logic [9:0] vel_add(input logic [9:0] p, input vel_t v);
        return v.neg ? p - {8'b0, v.mag} : p + {8'b0, v.mag};
    endfunction
endpackage

// File: rtl/breakout_render.sv
// Combinational pixel-to-object mapping: bricks over bar over round ball.
module breakout_render
    import breakout_pkg::*;
#(
    parameter int NUM_BLOCKS  = 3,
    parameter int BLOCK_X0    = 170,
    parameter int BLOCK_PITCH = 120
) (
    input  logic [9:0]            pix_x_i,
    input  logic [9:0]            pix_y_i,
    input  logic [9:0]            bar_x_i,
    input  logic [9:0]            bar_w_i,
    input  logic [9:0]            ball_x_i,
    input  logic [9:0]            ball_y_i,
    input  logic [NUM_BLOCKS-1:0] alive_i,
    output logic                  graph_on_o,
    output logic [2:0]            graph_rgb_o
);
    logic [NUM_BLOCKS-1:0] brick_px;
    logic [9:0]            bar_dx, ball_dx, ball_dy;
    logic [7:0]            ball_row;
    logic                  bar_px, ball_px;

    function automatic logic [7:0] ball_bitmap(input logic [2:0] row);
        case (row)
            3'd0, 3'd7: return 8'b0011_1100;
            3'd1, 3'd6: return 8'b0111_1110;
            default:    return 8'b1111_1111;
        endcase
    endfunction

    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_brick
        localparam logic [10:0] LEFT = 11'(BLOCK_X0 + i * BLOCK_PITCH);
        logic [10:0] dx;
        assign dx          = {1'b0, pix_x_i} - LEFT;
        assign brick_px[i] = alive_i[i] && (dx < BRICK_W) &&
                             (pix_y_i >= BRICK_TOP) && (pix_y_i <= BRICK_BOT);
    end

    // Unsigned differences wrap large when the pixel is left of/above the object.
    assign bar_dx   = pix_x_i - bar_x_i;
    assign bar_px   = (bar_dx < bar_w_i) && (pix_y_i >= BAR_TOP) && (pix_y_i <= BAR_BOT);
    assign ball_dx  = pix_x_i - ball_x_i;
    assign ball_dy  = pix_y_i - ball_y_i;
    assign ball_row = ball_bitmap(ball_dy[2:0]);
    assign ball_px  = (ball_dx < BALL_SZ) && (ball_dy < BALL_SZ) && ball_row[ball_dx[2:0]];

    always_comb begin
        graph_rgb_o = RGB_NONE;
        if (|brick_px)   graph_rgb_o = RGB_BRICK;
        else if (bar_px) graph_rgb_o = RGB_BAR;
        else if (ball_px) graph_rgb_o = RGB_BALL;
    end

    assign graph_on_o = (|brick_px) || bar_px || ball_px;
endmodule

// File: rtl/breakout_engine.sv
// Single-row breakout: bar, ball physics, brick mask, score/lives and game FSM, stepped once per frame.
module breakout_engine
    import breakout_pkg::*;
#(
    parameter int NUM_BLOCKS  = 3,
    parameter int BLOCK_X0    = 170,
    parameter int BLOCK_PITCH = 120,
    parameter int LIVES       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] btn,
    input  logic [1:0] level,
    input  logic       start,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       graph_on,
    output logic [2:0] graph_rgb,
    output logic [7:0] score,
    output logic [2:0] lives,
    output logic [2:0] game_state
);
    state_e                state_q;
    logic [NUM_BLOCKS-1:0] alive_q, alive_d, brick_ovl, brick_hit, brick_first;
    logic [7:0]            score_q, score_d;
    logic [2:0]            lives_q;
    vel_t                  vx_q, vy_q, vx_d, vy_d;
    logic [9:0]            bar_x_q, bar_x_d, bar_mv, bar_w, bar_half, bar_max;
    logic [9:0]            ball_x_q, ball_y_q, ball_x_d, ball_y_d, ball_r, ball_b, park_x;
    logic [1:0]            speed;
    logic                  tick, hit_l, hit_r, hit_t, bar_ovl, bar_hit, miss;

    assign tick     = (pix_y == TICK_ROW) && (pix_x == 10'd0);
    assign speed    = lvl_speed(level);
    assign bar_w    = lvl_bar_w(level);
    assign bar_half = {1'b0, bar_w[9:1]};
    assign bar_max  = PF_RIGHT + 10'd1 - bar_w;

    // Always clamp so a mid-game width change can't leave the bar past the wall.
    always_comb begin
        bar_mv = bar_x_q;
        if (btn[1])      bar_mv = bar_x_q + BAR_STEP;
        else if (btn[0]) bar_mv = (bar_x_q < PF_LEFT + BAR_STEP) ? PF_LEFT : bar_x_q - BAR_STEP;
        bar_x_d = (bar_mv > bar_max) ? bar_max : bar_mv;
    end

    assign park_x  = bar_x_d + bar_half - 10'd4;
    assign ball_r  = ball_x_q + (BALL_SZ - 10'd1);
    assign ball_b  = ball_y_q + (BALL_SZ - 10'd1);
    assign hit_l   = ball_x_q <= PF_LEFT;
    assign hit_r   = ball_r >= PF_RIGHT;
    assign hit_t   = ball_y_q <= PF_TOP;
    assign bar_ovl = (ball_x_q <= bar_x_q + bar_w - 10'd1) && (ball_r >= bar_x_q);
    assign bar_hit = !vy_q.neg && (vy_q.mag != 2'd0) && (ball_b >= BAR_TOP) && bar_ovl;
    assign miss    = (ball_y_q > BAR_BOT) && !bar_ovl;

    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_brick
        localparam logic [10:0] LEFT = 11'(BLOCK_X0 + i * BLOCK_PITCH);
        assign brick_ovl[i] = ({1'b0, ball_x_q} <= LEFT + BRICK_W - 11'd1) &&
                              ({1'b0, ball_r} >= LEFT) &&
                              (ball_y_q <= BRICK_BOT) && (ball_b >= BRICK_TOP);
    end

    // Only the lowest-index live brick is consumed per tick.
    assign brick_hit   = brick_ovl & alive_q;
    assign brick_first = brick_hit & (~brick_hit + NUM_BLOCKS'(1));
    assign alive_d     = alive_q & ~brick_first;
    assign score_d     = (|brick_hit && score_q != 8'hFF) ? score_q + 8'd1 : score_q;

    always_comb begin
        vx_d = vx_q;
        vy_d = vy_q;
        if (hit_t) vy_d = '{neg: 1'b0, mag: speed};
        if (bar_hit) begin
            vy_d = '{neg: 1'b1, mag: speed};
            vx_d = '{neg: (ball_x_q + 10'd4) < (bar_x_q + bar_half), mag: speed};
        end
        if (hit_l) vx_d = '{neg: 1'b0, mag: speed};
        if (hit_r) vx_d = '{neg: 1'b1, mag: speed};
        if (|brick_hit) vy_d = '{neg: ~vy_q.neg, mag: vy_q.mag};
    end

    assign ball_x_d = vel_add(ball_x_q, vx_d);
    assign ball_y_d = vel_add(ball_y_q, vy_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            alive_q  <= '1;
            score_q  <= '0;
            lives_q  <= 3'(LIVES);
            vx_q     <= '0;
            vy_q     <= '0;
            bar_x_q  <= BAR_X_RST;
            ball_x_q <= BALL_X_RST;
            ball_y_q <= BALL_Y_PARK;
        end else if (tick) begin
            // Outside RUN the ball sits on the bar, motionless.
            bar_x_q  <= bar_x_d;
            ball_x_q <= park_x;
            ball_y_q <= BALL_Y_PARK;
            vx_q     <= '0;
            vy_q     <= '0;
            case (state_q)
                ST_IDLE: if (start) state_q <= ST_SERVE;
                ST_SERVE: if (start) begin
                    vx_q    <= '{neg: 1'b1, mag: speed};
                    vy_q    <= '{neg: 1'b1, mag: speed};
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    ball_x_q <= ball_x_d;
                    ball_y_q <= ball_y_d;
                    vx_q     <= vx_d;
                    vy_q     <= vy_d;
                    alive_q  <= alive_d;
                    score_q  <= score_d;
                    if (alive_d == '0) state_q <= ST_WIN;
                    else if (miss)     state_q <= ST_MISS;
                end
                ST_MISS: begin
                    lives_q <= lives_q - 3'd1;
                    state_q <= (lives_q <= 3'd1) ? ST_OVER : ST_SERVE;
                end
                ST_OVER, ST_WIN: if (start) begin
                    alive_q <= '1;
                    score_q <= '0;
                    lives_q <= 3'(LIVES);
                    state_q <= ST_SERVE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign score      = score_q;
    assign lives      = lives_q;
    assign game_state = state_q;

    breakout_render #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .BLOCK_X0   (BLOCK_X0),
        .BLOCK_PITCH(BLOCK_PITCH)
    ) u_render (
        .pix_x_i    (pix_x),
        .pix_y_i    (pix_y),
        .bar_x_i    (bar_x_q),
        .bar_w_i    (bar_w),
        .ball_x_i   (ball_x_q),
        .ball_y_i   (ball_y_q),
        .alive_i    (alive_q),
        .graph_on_o (graph_on),
        .graph_rgb_o(graph_rgb)
    );
endmodule
